// File: rtl/periph_pkg.sv
// Shared definitions for the memory-mapped timer peripheral: register map,
// TCON bit positions and the bus address decoder.
package periph_pkg;

    localparam logic [31:0] TH_OFF   = 32'h0000_0000;
    localparam logic [31:0] TL_OFF   = 32'h0000_0004;
    localparam logic [31:0] TCON_OFF = 32'h0000_0008;

    localparam int EN_BIT = 0;
    localparam int IE_BIT = 1;
    localparam int IS_BIT = 2;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_TH   = 2'd1,
        REG_TL   = 2'd2,
        REG_TCON = 2'd3
    } reg_sel_e;

    // Map a CPU byte address onto one of the three registers; the two low
    // address bits are masked off so any byte inside a word selects it.
    function automatic reg_sel_e decode_reg(input logic [31:0] addr,
                                            input logic [31:0] base);
        logic [31:0] word;
        word = addr & ~32'h0000_0003;
        if (word == base + TH_OFF)
            return REG_TH;
        else if (word == base + TL_OFF)
            return REG_TL;
        else if (word == base + TCON_OFF)
            return REG_TCON;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/periph_timer.sv
// 32-bit reload timer: TL counts up on divider ticks, reloads from TH on
// overflow and flags a sticky interrupt status gated by IE.
module periph_timer
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        tick_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;

    reg_sel_e    sel;
    logic        wr_th;
    logic        wr_tl;
    logic        wr_tcon;
    logic        count;
    logic        overflow;

    assign sel      = decode_reg(addr, BASE_ADDR);
    assign wr_th    = mem_write && (sel == REG_TH);
    assign wr_tl    = mem_write && (sel == REG_TL);
    assign wr_tcon  = mem_write && (sel == REG_TCON);

    // Count and overflow decisions always use the pre-write TCON contents.
    assign count    = tcon[EN_BIT] && tick_en;
    assign overflow = count && (tl == 32'hFFFF_FFFF);

    // Register file update: CPU write to TL beats a count step, the reload
    // reads the old TH, and an overflow set of IS wins over a TCON write.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th)
                th <= wdata;

            if (wr_tl)
                tl <= wdata;
            else if (overflow)
                tl <= th;
            else if (count)
                tl <= tl + 32'd1;

            if (wr_tcon)
                tcon <= wdata[2:0];
            if (overflow && tcon[IE_BIT])
                tcon[IS_BIT] <= 1'b1;
        end
    end

    // Zero-wait-state read mux; returns 0 unless a read hits a register.
    always_comb begin
        rdata = '0;
        if (mem_read) begin
            case (sel)
                REG_TH:   rdata = th;
                REG_TL:   rdata = tl;
                REG_TCON: rdata = {29'd0, tcon};
                default:  rdata = '0;
            endcase
        end
    end

    assign irq = tcon[IE_BIT] & tcon[IS_BIT];

endmodule

// File: tb/tb_periph_timer.sv
// Directed self-checking bench for periph_timer.
module tb_periph_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        sysclk;
    logic        reset;
    logic        tick_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] rdata;
    logic        irq;

    int checks;
    int errors;

    periph_timer #(.BASE_ADDR(BASE)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .tick_en   (tick_en),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .rdata     (rdata),
        .irq       (irq)
    );

    // Free-running system clock.
    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Drive one bus/tick cycle from a falling edge, let the rising edge
    // consume it, and release the strobes on the following falling edge.
    task automatic applyStimulus(input logic we, input logic [31:0] off,
                                 input logic [31:0] data, input logic tick);
        @(negedge sysclk);
        mem_write = we;
        addr      = BASE + off;
        wdata     = data;
        tick_en   = tick;
        @(negedge sysclk);
        mem_write = 1'b0;
        tick_en   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a,
                             input logic [31:0] expected);
        mem_read = 1'b1;
        addr     = a;
        #1;
        checkOutput(tag, rdata, expected);
        mem_read = 1'b0;
    endtask

    // Linear directed test sequence.
    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        tick_en   = 1'b0;
        addr      = '0;
        wdata     = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;

        @(negedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        readCheck("reset_th",   BASE + 32'h0, 32'h0);
        readCheck("reset_tl",   BASE + 32'h4, 32'h0);
        readCheck("reset_tcon", BASE + 32'h8, 32'h0);
        checkOutput("reset_irq", {31'd0, irq}, 32'h0);

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        readCheck("tick_disabled_tl", BASE + 32'h4, 32'h0);

        applyStimulus(1'b1, 32'h0, 32'hFFFF_FFF0, 1'b0);
        applyStimulus(1'b1, 32'h4, 32'hFFFF_FFFD, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h0000_0003, 1'b0);
        readCheck("write_th",   BASE + 32'h0, 32'hFFFF_FFF0);
        readCheck("write_tcon", BASE + 32'h8, 32'h0000_0003);

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        readCheck("count_1", BASE + 32'h4, 32'hFFFF_FFFE);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        readCheck("count_2", BASE + 32'h4, 32'hFFFF_FFFF);
        checkOutput("irq_before_ovf", {31'd0, irq}, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        readCheck("reload", BASE + 32'h4, 32'hFFFF_FFF0);
        readCheck("is_set", BASE + 32'h8, 32'h0000_0007);
        checkOutput("irq_after_ovf", {31'd0, irq}, 32'h1);

        applyStimulus(1'b1, 32'h8, 32'h0000_0003, 1'b0);
        checkOutput("irq_cleared", {31'd0, irq}, 32'h0);
        readCheck("is_cleared", BASE + 32'h8, 32'h0000_0003);

        applyStimulus(1'b1, 32'h8, 32'h0000_0001, 1'b0);
        applyStimulus(1'b1, 32'h4, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        readCheck("masked_reload", BASE + 32'h4, 32'hFFFF_FFF0);
        readCheck("masked_is",     BASE + 32'h8, 32'h0000_0001);
        checkOutput("masked_irq", {31'd0, irq}, 32'h0);

        applyStimulus(1'b1, 32'h8, 32'h0000_0003, 1'b0);
        applyStimulus(1'b1, 32'h4, 32'd5, 1'b0);
        applyStimulus(1'b1, 32'h4, 32'd100, 1'b1);
        readCheck("tl_write_wins", BASE + 32'h4, 32'd100);

        applyStimulus(1'b1, 32'h4, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h0000_0003, 1'b1);
        readCheck("tcon_collide_is", BASE + 32'h8, 32'h0000_0007);
        readCheck("tcon_collide_tl", BASE + 32'h4, 32'hFFFF_FFF0);
        checkOutput("tcon_collide_irq", {31'd0, irq}, 32'h1);

        applyStimulus(1'b1, 32'h4, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b1, 32'h0, 32'd7, 1'b1);
        readCheck("th_collide_old", BASE + 32'h4, 32'hFFFF_FFF0);
        readCheck("th_collide_new", BASE + 32'h0, 32'd7);
        applyStimulus(1'b1, 32'h4, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        readCheck("th_next_reload", BASE + 32'h4, 32'd7);

        readCheck("unmapped_c",    BASE + 32'hC, 32'h0);
        readCheck("outside_block", 32'h5000_0000, 32'h0);
        readCheck("byte_alias_tl", BASE + 32'h5, 32'd7);
        applyStimulus(1'b1, 32'hC, 32'hDEAD_BEEF, 1'b0);
        readCheck("unmapped_wr_th",   BASE + 32'h0, 32'd7);
        readCheck("unmapped_wr_tl",   BASE + 32'h4, 32'd7);
        readCheck("unmapped_wr_tcon", BASE + 32'h8, 32'h0000_0007);
        mem_read = 1'b0;
        addr     = BASE + 32'h0;
        #1;
        checkOutput("no_read_strobe", rdata, 32'h0);

        applyStimulus(1'b1, 32'h4, 32'h0000_1234, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h0000_0007, 1'b0);
        checkOutput("pre_reset_irq", {31'd0, irq}, 32'h1);
        tick_en = 1'b1;
        @(negedge sysclk);
        readCheck("held_tick", BASE + 32'h4, 32'h0000_1235);
        reset     = 1'b1;
        mem_write = 1'b1;
        addr      = BASE + 32'h4;
        wdata     = 32'd9;
        @(negedge sysclk);
        reset     = 1'b0;
        mem_write = 1'b0;
        tick_en   = 1'b0;
        readCheck("midreset_th",   BASE + 32'h0, 32'h0);
        readCheck("midreset_tl",   BASE + 32'h4, 32'h0);
        readCheck("midreset_tcon", BASE + 32'h8, 32'h0);
        checkOutput("midreset_irq", {31'd0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
